mem_wb_writeback: RTL and testbench

//  MEM/WB pipeline register plus writeback datapath; the write-side driver of the register file.

---
 rtl/mem_wb_writeback.sv | 150 +++++++++++++++
 tb/tb_mem_wb_writeback.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// ============================================================================
// Module   : mem_wb_writeback
// Purpose  : MEM/WB pipeline register and writeback datapath. It aligns and
//            extends load data, then drives the register file write port,
//            a forwarding view and a retired-instruction counter.
//            The optional jal/jalr link path is enabled by defining WB_LINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_writeback #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             MemValid,
  input  logic             MemRegWrite,
  input  logic             MemToReg,
  input  logic [2:0]       MemLoadType,
  input  logic [4:0]       MemWriteRegister,
  input  logic [31:0]      MemAluResult,
  input  logic [31:0]      MemReadData,
  input  logic             MemLink,
  input  logic [31:0]      MemPcPlus4,
  output logic [4:0]       WriteRegister,
  output logic [31:0]      WriteData,
  output logic             RegWrite,
  output logic             FwdValid,
  output logic [4:0]       FwdRegister,
  output logic [31:0]      FwdData,
  output logic             MisalignedLoad,
  output logic [CNT_W-1:0] RetireCount
);

  localparam logic [2:0] c_LD_LH  = 3'd1;
  localparam logic [2:0] c_LD_LHU = 3'd2;
  localparam logic [2:0] c_LD_LB  = 3'd3;
  localparam logic [2:0] c_LD_LBU = 3'd4;

  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             regwrite_q, regwrite_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] retire_q;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_addr_bad;
  logic        w_link;

`ifdef WB_LINK_EN
  assign w_link = MemLink;
`else
  assign w_link = 1'b0;
  logic w_unused_link;
  assign w_unused_link = &{1'b0, MemLink, MemPcPlus4};
`endif

  // Big-endian lane selection: offset 0 is the most significant byte/half.
  always_comb begin
    w_byte = MemReadData[31:24];
    case (MemAluResult[1:0])
      2'd0: w_byte = MemReadData[31:24];
      2'd1: w_byte = MemReadData[23:16];
      2'd2: w_byte = MemReadData[15:8];
      2'd3: w_byte = MemReadData[7:0];
      default: w_byte = MemReadData[31:24];
    endcase
    w_half = MemAluResult[1] ? MemReadData[15:0] : MemReadData[31:16];
  end

  always_comb begin
    w_load     = MemReadData;
    w_addr_bad = (MemAluResult[1:0] != 2'd0);
    case (MemLoadType)
      c_LD_LH: begin
        w_load     = {{16{w_half[15]}}, w_half};
        w_addr_bad = MemAluResult[0];
      end
      c_LD_LHU: begin
        w_load     = {16'h0000, w_half};
        w_addr_bad = MemAluResult[0];
      end
      c_LD_LB: begin
        w_load     = {{24{w_byte[7]}}, w_byte};
        w_addr_bad = 1'b0;
      end
      c_LD_LBU: begin
        w_load     = {24'h000000, w_byte};
        w_addr_bad = 1'b0;
      end
      default: begin
        w_load     = MemReadData;
        w_addr_bad = (MemAluResult[1:0] != 2'd0);
      end
    endcase
  end

  always_comb begin
    misaligned_d = MemValid & MemToReg & w_addr_bad & ~w_link;
    wreg_d       = MemWriteRegister;
    wdata_d      = MemToReg ? w_load : MemAluResult;
`ifdef WB_LINK_EN
    if (w_link) begin
      wreg_d  = 5'd31;
      wdata_d = MemPcPlus4;
    end
`endif
    regwrite_d = MemValid & MemRegWrite & (wreg_d != 5'd0) & ~misaligned_d;
  end

  // Flush wins over Stall; the counter only moves on an unstalled capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wreg_q       <= 5'd0;
      wdata_q      <= 32'd0;
      regwrite_q   <= 1'b0;
      misaligned_q <= 1'b0;
      retire_q     <= '0;
    end else if (Flush) begin
      wreg_q       <= 5'd0;
      wdata_q      <= 32'd0;
      regwrite_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (!Stall) begin
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      regwrite_q   <= regwrite_d;
      misaligned_q <= misaligned_d;
      if (MemValid) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign WriteRegister  = wreg_q;
  assign WriteData      = wdata_q;
  assign RegWrite       = regwrite_q;
  assign FwdValid       = regwrite_q;
  assign FwdRegister    = wreg_q;
  assign FwdData        = wdata_q;
  assign MisalignedLoad = misaligned_q;
  assign RetireCount    = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_writeback.sv
// ============================================================================
// Module   : tb_mem_wb_writeback
// Purpose  : Directed and randomized checks of mem_wb_writeback against a
//            behavioural writeback model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush, MemValid, MemRegWrite, MemToReg, MemLink;
  logic [2:0]  MemLoadType;
  logic [4:0]  MemWriteRegister;
  logic [31:0] MemAluResult, MemReadData, MemPcPlus4;
  logic [4:0]  WriteRegister, FwdRegister;
  logic [31:0] WriteData, FwdData;
  logic        RegWrite, FwdValid, MisalignedLoad;
  logic [31:0] RetireCount;

  int checks   = 0;
  int failures = 0;

  // Expected architectural view of the WB stage
  logic        m_rw, m_mis, m_known;
  logic [4:0]  m_wr;
  logic [31:0] m_wd, m_cnt;

  always #5 clk = ~clk;

  mem_wb_writeback #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemToReg(MemToReg),
    .MemLoadType(MemLoadType), .MemWriteRegister(MemWriteRegister),
    .MemAluResult(MemAluResult), .MemReadData(MemReadData),
    .MemLink(MemLink), .MemPcPlus4(MemPcPlus4),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .FwdValid(FwdValid), .FwdRegister(FwdRegister), .FwdData(FwdData),
    .MisalignedLoad(MisalignedLoad), .RetireCount(RetireCount)
  );

  function automatic logic [31:0] load_value(logic [2:0] t, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * (3 - int'(a)))) & 32'hFF);
    h = 16'((w >> (16 * (1 - int'(a[1])))) & 32'hFFFF);
    case (t)
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0, h};
      3'd3:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      default: return w;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [2:0] t, logic [1:0] a);
    if (t == 3'd1 || t == 3'd2) return a[0];
    if (t == 3'd3 || t == 3'd4) return 1'b0;
    return a != 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'(m_rw));
    chk({tag, "_fwdvalid"}, 32'(FwdValid), 32'(m_rw));
    chk({tag, "_misaligned"}, 32'(MisalignedLoad), 32'(m_mis));
    chk({tag, "_retire"}, RetireCount, m_cnt);
    if (m_known) begin
      chk({tag, "_wreg"}, 32'(WriteRegister), 32'(m_wr));
      chk({tag, "_wdata"}, WriteData, m_wd);
      chk({tag, "_fwdreg"}, 32'(FwdRegister), 32'(m_wr));
      chk({tag, "_fwddata"}, FwdData, m_wd);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check after it.
  task automatic step(input string tag, input logic rst, input logic st, input logic fl,
                      input logic v, input logic rw, input logic mtr, input logic [2:0] lt,
                      input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd,
                      input logic lk, input logic [31:0] pc);
    logic        mis, link;
    logic [4:0]  r;
    logic [31:0] d;
    reset = rst; Stall = st; Flush = fl; MemValid = v; MemRegWrite = rw;
    MemToReg = mtr; MemLoadType = lt; MemWriteRegister = wr; MemAluResult = alu;
    MemReadData = rd; MemLink = lk; MemPcPlus4 = pc;
    @(posedge clk);
`ifdef WB_LINK_EN
    link = lk;
`else
    link = 1'b0;
`endif
    if (rst) begin
      m_rw = 0; m_mis = 0; m_wr = 0; m_wd = 0; m_cnt = 0; m_known = 1;
    end else if (fl) begin
      m_rw = 0; m_mis = 0; m_wr = 0; m_wd = 0; m_known = 1;
    end else if (!st) begin
      mis = v && mtr && !link && is_misaligned(lt, alu[1:0]);
      r   = link ? 5'd31 : wr;
      d   = link ? pc : (mtr ? load_value(lt, alu[1:0], rd) : alu);
      m_rw    = v && rw && (r != 0) && !mis;
      m_mis   = mis;
      m_wr    = r;
      m_wd    = d;
      m_known = v;
      if (v) m_cnt = m_cnt + 1;
    end
    #1;
    chk_model(tag);
  endtask

  initial begin
    m_rw = 0; m_mis = 0; m_wr = 0; m_wd = 0; m_cnt = 0; m_known = 0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_regwrite", 32'(RegWrite), 0);
    chk("reset_retire", RetireCount, 0);

    step("alu_r8", 0, 0, 0, 1, 1, 0, 0, 5'd8, 32'h12345678, 32'h0, 0, 0);
    chk("alu_r8_data", WriteData, 32'h12345678);
    chk("alu_r8_reg", 32'(WriteRegister), 8);
    chk("alu_r8_cnt", RetireCount, 1);

    step("lb", 0, 0, 0, 1, 1, 1, 3'd3, 5'd4, 32'h1002, 32'h11AA8033, 0, 0);
    chk("lb_data", WriteData, 32'hFFFFFF80);
    step("lbu", 0, 0, 0, 1, 1, 1, 3'd4, 5'd4, 32'h1002, 32'h11AA8033, 0, 0);
    chk("lbu_data", WriteData, 32'h00000080);
    step("lhu", 0, 0, 0, 1, 1, 1, 3'd2, 5'd4, 32'h1000, 32'h11AA8033, 0, 0);
    chk("lhu_data", WriteData, 32'h000011AA);

    step("lw_mis", 0, 0, 0, 1, 1, 1, 3'd0, 5'd6, 32'h1001, 32'hCAFEF00D, 0, 0);
    chk("lw_mis_flag", 32'(MisalignedLoad), 1);
    chk("lw_mis_rw", 32'(RegWrite), 0);
    chk("lw_mis_cnt", RetireCount, 5);
    step("after_mis", 0, 0, 0, 1, 1, 0, 3'd0, 5'd7, 32'h77, 32'h0, 0, 0);
    chk("after_mis_flag", 32'(MisalignedLoad), 0);

    step("r0", 0, 0, 0, 1, 1, 0, 3'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 0, 0);
    chk("r0_fwdvalid", 32'(FwdValid), 0);

    step("r5", 0, 0, 0, 1, 1, 0, 3'd0, 5'd5, 32'h55555555, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 1, 1, 0, 3'd0, 5'd9, 32'hDEADBEEF, 32'h0, 0, 0);
      chk("stall_data", WriteData, 32'h55555555);
      chk("stall_cnt", RetireCount, 8);
    end

    step("r9", 0, 0, 0, 1, 1, 0, 3'd0, 5'd9, 32'h99, 32'h0, 0, 0);
    step("flush_stall", 0, 1, 1, 1, 1, 0, 3'd0, 5'd10, 32'hAA, 32'h0, 0, 0);
    chk("flush_reg", 32'(WriteRegister), 0);
    chk("flush_rw", 32'(RegWrite), 0);

    step("pre_rst", 0, 0, 0, 1, 1, 0, 3'd0, 5'd12, 32'h1234, 32'h0, 0, 0);
    step("mid_rst", 1, 0, 0, 1, 1, 0, 3'd0, 5'd12, 32'h1234, 32'h0, 0, 0);
    chk("mid_rst_cnt", RetireCount, 0);
    chk("mid_rst_data", WriteData, 0);

    step("link", 0, 0, 0, 1, 1, 0, 3'd0, 5'd3, 32'h5A5A, 32'h0, 1, 32'h00400008);
`ifdef WB_LINK_EN
    chk("link_reg", 32'(WriteRegister), 31);
    chk("link_data", WriteData, 32'h00400008);
`else
    chk("link_reg", 32'(WriteRegister), 3);
    chk("link_data", WriteData, 32'h5A5A);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [4:0] wr;
      wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step("rand",
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 4) != 0), 1'($urandom), 3'($urandom), wr,
           $urandom, $urandom, ($urandom_range(0, 5) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
